// File: rtl/tt_um_hoene_manchester_decoder_pkg.sv
// tt_um_hoene_manchester_decoder_pkg: shared widths and FSM states for the Manchester receive/forward chain
package tt_um_hoene_manchester_decoder_pkg;
  localparam int CNT_W = 7;
  localparam int PW_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW_W-2:0] H_MAX = '1;
  typedef enum logic [1:0] {IDLE, MEASURE, DATA, WAIT_LOW} state_t;
endpackage

// File: rtl/tt_um_hoene_manchester_decoder_if.sv
// tt_um_hoene_manchester_decoder_if: serial line in, recovered bit stream and pulse width out
interface tt_um_hoene_manchester_decoder_if;
  import tt_um_hoene_manchester_decoder_pkg::*;
  logic in_line;
  logic out_data;
  logic out_clk;
  logic [PW_W-1:0] out_pulsewidth;
  logic out_active;
  logic out_frame_end;
  modport master(input in_line, output out_data, out_clk, out_pulsewidth, out_active, out_frame_end);
  modport slave(output in_line, input out_data, out_clk, out_pulsewidth, out_active, out_frame_end);
endinterface

// File: rtl/tt_um_hoene_sync_edge.sv
// tt_um_hoene_sync_edge: multi-flop synchronizer with a delayed copy for edge detection
module tt_um_hoene_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic edge_det
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev <= sync_q[SYNC_STAGES-1];
    end
  end
  assign level = sync_q[SYNC_STAGES-1];
  assign edge_det = level ^ prev;
endmodule

// File: rtl/tt_um_hoene_manchester_decoder.sv
// tt_um_hoene_manchester_decoder: recovers Manchester bits and the bit period measured from the start bit
module tt_um_hoene_manchester_decoder
  import tt_um_hoene_manchester_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF = 2
) (
  input logic clk,
  input logic rst_n,
  tt_um_hoene_manchester_decoder_if.master bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, q_lim, t_lim;
  logic [PW_W-2:0] h, h_n, h_clamp;
  logic [PW_W-1:0] pw, pw_n;
  logic level, edge_det, data, data_n, strobe, strobe_n, fe, fe_n, active;
  tt_um_hoene_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .din(bus.in_line), .level(level), .edge_det(edge_det)
  );
  assign h_clamp = (cnt > CNT_W'(H_MAX)) ? H_MAX : cnt[PW_W-2:0];
  // Mid-bit edges land near 2H after the last one, boundary edges near H; 1.5H splits them
  assign q_lim = CNT_W'(h) + CNT_W'(h >> 1);
  assign t_lim = q_lim + CNT_W'(h);
  always_comb begin
    state_n = state;
    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    h_n = h;
    pw_n = pw;
    data_n = data;
    strobe_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: if (edge_det && level) begin
        state_n = MEASURE;
        cnt_n = CNT_W'(1);
      end
      MEASURE: if (edge_det && !level) begin
        if (cnt < CNT_W'(MIN_HALF)) state_n = IDLE;
        else begin
          h_n = h_clamp;
          pw_n = {h_clamp, 1'b0};
          data_n = 1'b1;
          strobe_n = 1'b1;
          cnt_n = CNT_W'(1);
          state_n = DATA;
        end
      end else if (cnt == CNT_MAX) state_n = WAIT_LOW;
      DATA: if (edge_det) begin
        if (cnt >= q_lim) begin
          data_n = !level;
          strobe_n = 1'b1;
          cnt_n = CNT_W'(1);
        end
      end else if (cnt > t_lim) begin
        fe_n = 1'b1;
        state_n = level ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: if (!level) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      h <= '0;
      pw <= '0;
      data <= 1'b0;
      strobe <= 1'b0;
      fe <= 1'b0;
      active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      h <= h_n;
      pw <= pw_n;
      data <= data_n;
      strobe <= strobe_n;
      fe <= fe_n;
      active <= (state_n == DATA);
    end
  end
  assign bus.out_data = data;
  assign bus.out_clk = strobe;
  assign bus.out_pulsewidth = pw;
  assign bus.out_active = active;
  assign bus.out_frame_end = fe;
endmodule
